// File: rtl/h3_sec_scrubber.sv
// h3_sec_scrubber
// Sits behind the Hamming SEC corrector. It extracts the K data bits from each
// corrected codeword and streams them out over valid/ready. When the word had
// a corrected single error, it then requests a scrub write-back of the
// corrected codeword to the word's source address. It also keeps a saturating
// count of SEC events for the monitoring registers.
//
// Ports
//   clk, rst              single rising-edge clock, synchronous active-high reset
//   valid_i / ready_o     input handshake for hamming_corrected_i, sec_i, addr_i
//   data_valid_o / data_ready_i / data_o
//                         extracted data stream
//   scrub_req_o / scrub_ack_i / scrub_addr_o / scrub_data_o
//                         scrub write-back request, held until acknowledged
//   count_clr_i           clears the SEC counter and the saturation flag
//   sec_count_o / sec_sat_o
//                         SEC event count and sticky saturation flag
module h3_sec_scrubber #(
  parameter int N      = 15,
  parameter int K      = 11,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [N-1:0]      hamming_corrected_i,
  input  logic              sec_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic [K-1:0]      data_o,
  output logic              scrub_req_o,
  input  logic              scrub_ack_i,
  output logic [ADDR_W-1:0] scrub_addr_o,
  output logic [N-1:0]      scrub_data_o,
  input  logic              count_clr_i,
  output logic [CNT_W-1:0]  sec_count_o,
  output logic              sec_sat_o
);

  if (!((N == 15 && K == 11) || (N == 7 && K == 4))) begin : g_bad_params
    $error("h3_sec_scrubber: (N,K) must be (15,11) or (7,4)");
  end

  typedef enum logic [1:0] {S_IDLE, S_OUT, S_SCRUB} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state_reg, state_next;
  logic [N-1:0]        cw_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                sec_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                sat_reg;
  logic                accept;
  logic                count_inc;
  logic [K-1:0]        data_bits;

  // Hamming position (1-based) of the j-th data bit: the j-th position that
  // is not a power of two.
  function automatic int data_pos(input int j);
    int cnt;
    data_pos = 0;
    cnt      = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == j) data_pos = p;
        cnt++;
      end
    end
  endfunction

  for (genvar gi = 0; gi < K; gi++) begin : g_extract
    localparam int POS = data_pos(gi);
    assign data_bits[gi] = cw_reg[POS-1];
  end

  // Next-state and handshake outputs. rst forces every output low in the
  // same cycle it is sampled, so nothing is accepted or offered during reset.
  always_comb begin
    state_next   = state_reg;
    ready_o      = 1'b0;
    data_valid_o = 1'b0;
    scrub_req_o  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_next = S_OUT;
      end
      S_OUT: begin
        data_valid_o = 1'b1;
        if (data_ready_i) begin
          if (!sec_reg) begin
            // Clean word leaving: take the next one in the same cycle.
            ready_o    = 1'b1;
            state_next = valid_i ? S_OUT : S_IDLE;
          end else begin
            state_next = S_SCRUB;
          end
        end
      end
      S_SCRUB: begin
        scrub_req_o = 1'b1;
        if (scrub_ack_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (rst) begin
      ready_o      = 1'b0;
      data_valid_o = 1'b0;
      scrub_req_o  = 1'b0;
    end
  end

  assign accept    = valid_i & ready_o;
  assign count_inc = accept & sec_i;

  assign data_o       = data_valid_o ? data_bits : '0;
  assign scrub_addr_o = scrub_req_o ? addr_reg : '0;
  assign scrub_data_o = scrub_req_o ? cw_reg : '0;
  assign sec_count_o  = rst ? '0 : count_reg;
  assign sec_sat_o    = rst ? 1'b0 : sat_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cw_reg    <= '0;
      addr_reg  <= '0;
      sec_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cw_reg   <= hamming_corrected_i;
        addr_reg <= addr_i;
        sec_reg  <= sec_i;
      end
    end
  end

  // SEC counter runs independently of the FSM. A clear that coincides with a
  // counted accept keeps that event, so the count restarts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      sat_reg   <= 1'b0;
    end else if (count_clr_i) begin
      count_reg <= {{(CNT_W-1){1'b0}}, count_inc};
      sat_reg   <= 1'b0;
    end else if (count_inc && count_reg != CNT_MAX) begin
      count_reg <= count_reg + 1'b1;
      if (count_reg == CNT_MAX - 1'b1) sat_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_h3_sec_scrubber.sv
// Randomized and directed bench for h3_sec_scrubber (N=15, K=11, CNT_W=4).
// A transaction-level reference model (word occupancy, pending scrub, event
// count) predicts every output each cycle.
module tb_h3_sec_scrubber;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [14:0] hamming_corrected_i;
  logic        sec_i;
  logic [7:0]  addr_i;
  logic        data_valid_o;
  logic        data_ready_i;
  logic [10:0] data_o;
  logic        scrub_req_o;
  logic        scrub_ack_i;
  logic [7:0]  scrub_addr_o;
  logic [14:0] scrub_data_o;
  logic        count_clr_i;
  logic [3:0]  sec_count_o;
  logic        sec_sat_o;

  h3_sec_scrubber #(.N(15), .K(11), .ADDR_W(8), .CNT_W(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .valid_i             (valid_i),
    .ready_o             (ready_o),
    .hamming_corrected_i (hamming_corrected_i),
    .sec_i               (sec_i),
    .addr_i              (addr_i),
    .data_valid_o        (data_valid_o),
    .data_ready_i        (data_ready_i),
    .data_o              (data_o),
    .scrub_req_o         (scrub_req_o),
    .scrub_ack_i         (scrub_ack_i),
    .scrub_addr_o        (scrub_addr_o),
    .scrub_data_o        (scrub_data_o),
    .count_clr_i         (count_clr_i),
    .sec_count_o         (sec_count_o),
    .sec_sat_o           (sec_sat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Data bits sit at the non-power-of-two Hamming positions, ascending.
  function automatic logic [10:0] extract(input logic [14:0] cw);
    int pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    logic [10:0] r;
    for (int j = 0; j < 11; j++) r[j] = cw[pos[j]-1];
    return r;
  endfunction

  // Reference model: at most one word held for output, at most one scrub pending.
  bit          m_has;
  logic [14:0] m_cw;
  logic [7:0]  m_addr;
  bit          m_sec;
  bit          m_scrub;
  logic [14:0] m_scw;
  logic [7:0]  m_saddr;
  int          m_count;
  bit          m_sat;
  bit          m_acc;

  // Observed outputs of the latest cycle, for directed checks.
  logic        obs_ready, obs_dv, obs_req, obs_sat;
  logic [10:0] obs_data;
  logic [7:0]  obs_saddr;
  logic [14:0] obs_sdata;
  logic [3:0]  obs_count;

  task automatic cycle(input bit r, input bit v, input logic [14:0] cw, input bit s,
                       input logic [7:0] a, input bit dr, input bit ack, input bit clr);
    bit          e_ready, e_dv, e_req, e_sat;
    logic [10:0] e_data;
    logic [7:0]  e_saddr;
    logic [14:0] e_sdata;
    int          e_count;
    @(negedge clk);
    rst = r; valid_i = v; hamming_corrected_i = cw; sec_i = s; addr_i = a;
    data_ready_i = dr; scrub_ack_i = ack; count_clr_i = clr;
    #1;
    e_ready = 0; e_dv = 0; e_req = 0; e_data = '0; e_saddr = '0; e_sdata = '0;
    e_count = m_count; e_sat = m_sat;
    if (r) begin
      e_count = 0; e_sat = 0;
    end else if (m_scrub) begin
      e_req = 1; e_saddr = m_saddr; e_sdata = m_scw;
    end else if (m_has) begin
      e_dv = 1; e_data = extract(m_cw); e_ready = dr && !m_sec;
    end else begin
      e_ready = 1;
    end
    chk("ready", ready_o, e_ready);
    chk("data_valid", data_valid_o, e_dv);
    chk("data", data_o, e_data);
    chk("scrub_req", scrub_req_o, e_req);
    chk("scrub_addr", scrub_addr_o, e_saddr);
    chk("scrub_data", scrub_data_o, e_sdata);
    chk("count", sec_count_o, e_count);
    chk("sat", sec_sat_o, e_sat);
    obs_ready = ready_o; obs_dv = data_valid_o; obs_req = scrub_req_o; obs_sat = sec_sat_o;
    obs_data = data_o; obs_saddr = scrub_addr_o; obs_sdata = scrub_data_o; obs_count = sec_count_o;
    // Advance the model to the state after the coming rising edge.
    m_acc = !r && v && e_ready;
    if (r) begin
      m_has = 0; m_scrub = 0; m_count = 0; m_sat = 0;
    end else begin
      if (m_scrub) begin
        if (ack) m_scrub = 0;
      end else if (m_has && dr) begin
        if (m_sec) begin
          m_scrub = 1; m_scw = m_cw; m_saddr = m_addr; m_has = 0;
        end else begin
          m_has = 0;
        end
      end
      if (m_acc) begin
        m_has = 1; m_cw = cw; m_addr = a; m_sec = s;
      end
      if (clr) begin
        m_count = (m_acc && s) ? 1 : 0;
        m_sat = 0;
      end else if (m_acc && s && m_count < 15) begin
        m_count++;
        if (m_count == 15) m_sat = 1;
      end
    end
  endtask

  task automatic idle(input bit dr, input bit ack);
    cycle(0, 0, 15'h0, 0, 8'h0, dr, ack, 0);
  endtask

  initial begin
    int n_sec;
    int guard;
    logic [14:0] held;
    rst = 1; valid_i = 0; hamming_corrected_i = '0; sec_i = 0; addr_i = '0;
    data_ready_i = 0; scrub_ack_i = 0; count_clr_i = 0;
    m_has = 0; m_scrub = 0; m_count = 0; m_sat = 0; m_sec = 0; m_acc = 0;
    m_cw = '0; m_addr = '0; m_scw = '0; m_saddr = '0;

    // Reset with every input toggling.
    for (int i = 0; i < 3; i++)
      cycle(1, 1, 15'($urandom), 1, 8'($urandom), 1, 1, i[0]);
    idle(1, 0);
    chk("rst_release_ready", obs_ready, 1);

    // Clean word.
    cycle(0, 1, 15'h7FFF, 0, 8'h11, 1, 0, 0);
    idle(1, 0);
    chk("clean_data", obs_data, 11'h7FF);
    chk("clean_no_scrub", obs_req, 0);
    idle(1, 0);
    chk("clean_count", obs_count, 0);

    // SEC word, scrub acknowledged on its 4th request cycle.
    cycle(0, 1, 15'h0004, 1, 8'h2A, 1, 0, 0);
    idle(1, 0);
    chk("sec_data", obs_data, 11'h001);
    for (int i = 0; i < 4; i++) begin
      idle(1, i == 3);
      chk("scrub_hold_req", obs_req, 1);
      chk("scrub_hold_addr", obs_saddr, 8'h2A);
      chk("scrub_hold_data", obs_sdata, 15'h0004);
    end
    idle(1, 0);
    chk("scrub_done_req", obs_req, 0);
    chk("scrub_done_count", obs_count, 1);

    // Backpressure for 5 cycles, then back-to-back clean words.
    held = 15'h5A3C;
    cycle(0, 1, held, 0, 8'h33, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 15'($urandom), 0, 8'($urandom), 0, 0, 0);
      chk("bp_data", obs_data, extract(held));
      chk("bp_ready", obs_ready, 0);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 15'($urandom), 0, 8'($urandom), 1, 0, 0);
      chk("b2b_ready", obs_ready, 1);
    end
    idle(1, 0);

    // Saturation at CNT_W=4, then clear together with a counted accept.
    cycle(1, 0, 15'h0, 0, 8'h0, 0, 0, 0);
    n_sec = 0;
    guard = 0;
    while (n_sec < 16 && guard < 300) begin
      cycle(0, 1, 15'($urandom), 1, 8'($urandom), 1, 1, 0);
      if (m_acc) n_sec++;
      guard++;
    end
    chk("sat_events_accepted", n_sec, 16);
    idle(1, 1);
    chk("sat_count", obs_count, 15);
    chk("sat_flag", obs_sat, 1);
    guard = 0;
    while ((m_has || m_scrub) && guard < 20) begin
      idle(1, 1);
      guard++;
    end
    chk("sat_drain", m_has || m_scrub, 0);
    cycle(0, 1, 15'h0100, 1, 8'h44, 1, 1, 1);
    idle(1, 1);
    chk("clr_acc_count", obs_count, 1);
    chk("clr_acc_sat", obs_sat, 0);
    for (int i = 0; i < 4; i++) idle(1, 1);

    // Reset while a scrub is pending.
    cycle(0, 1, 15'h0040, 1, 8'h77, 1, 0, 0);
    idle(1, 0);
    idle(1, 0);
    chk("mid_scrub_req", obs_req, 1);
    cycle(1, 0, 15'h0, 0, 8'h0, 1, 0, 0);
    idle(1, 1);
    chk("post_rst_req", obs_req, 0);
    chk("post_rst_count", obs_count, 0);
    chk("post_rst_ready", obs_ready, 1);
    idle(1, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 199) == 0, ($urandom % 4) != 0, 15'($urandom),
            ($urandom % 3) == 0, 8'($urandom), ($urandom % 4) != 0,
            ($urandom % 3) == 0, ($urandom % 50) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
